// File: rtl/next_hop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : next_hop_pkg
// Description : Shared widths, broadcast MAC and FSM encoding for the
//               next-hop resolver.
// Revision    : 1.0 - initial release
// ============================================================================
package next_hop_pkg;

    localparam int IP_W  = 32;
    localparam int MAC_W = 48;

    localparam logic [MAC_W-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_LOOKUP    = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/next_hop_resolver.sv
`default_nettype none
// ============================================================================
// Module      : next_hop_resolver
// Description : Resolves the next-hop MAC of one outbound IPv4 destination via
//               the broadcast/locality checker and the ARP cache.
//               Optional macro NEXT_HOP_RETRY_EN enables ARP lookup retries.
// Revision    : 1.0 - initial release
// ============================================================================
module next_hop_resolver
    import next_hop_pkg::*;
#(
    parameter int CHK_LATENCY    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_req_valid,
    output logic              s_req_ready,
    input  logic [IP_W-1:0]   s_req_ip,
    input  logic [IP_W-1:0]   gateway_ip,
    output logic [IP_W-1:0]   chk_dest_ip,
    input  logic              chk_is_broadcast,
    input  logic              chk_is_subnet_broadcast,
    input  logic              chk_is_local,
    output logic              arp_req_valid,
    input  logic              arp_req_ready,
    output logic [IP_W-1:0]   arp_req_ip,
    input  logic              arp_resp_valid,
    output logic              arp_resp_ready,
    input  logic              arp_resp_error,
    input  logic [MAC_W-1:0]  arp_resp_mac,
    output logic              m_res_valid,
    input  logic              m_res_ready,
    output logic [MAC_W-1:0]  m_res_mac,
    output logic              m_res_bcast,
    output logic              m_res_error,
    output logic              busy
);

    localparam int CNT_W = $clog2(max_int(CHK_LATENCY, TIMEOUT_CYCLES) + 1);

    localparam logic [CNT_W-1:0] c_chk_load     = CNT_W'(CHK_LATENCY);
    localparam logic [CNT_W-1:0] c_timeout_load = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IP_W-1:0]    r_gateway;

`ifdef NEXT_HOP_RETRY_EN
    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [RETRY_W-1:0] c_max_retries = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] c_retry_one   = RETRY_W'(1);

    logic [RETRY_W-1:0] r_retry;
`else
    logic w_unused_max_retries;
    assign w_unused_max_retries = (MAX_RETRIES != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_gateway      <= '0;
`ifdef NEXT_HOP_RETRY_EN
            r_retry        <= '0;
`endif
            s_req_ready    <= 1'b0;
            chk_dest_ip    <= '0;
            arp_req_valid  <= 1'b0;
            arp_req_ip     <= '0;
            arp_resp_ready <= 1'b0;
            m_res_valid    <= 1'b0;
            m_res_mac      <= '0;
            m_res_bcast    <= 1'b0;
            m_res_error    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            // Responses outside WAIT_RESP are simply dropped.
            arp_resp_ready <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    s_req_ready <= 1'b1;
                    if (s_req_valid && s_req_ready) begin
                        s_req_ready <= 1'b0;
                        chk_dest_ip <= s_req_ip;
                        r_gateway   <= gateway_ip;
                        r_cnt       <= c_chk_load;
                        busy        <= 1'b1;
`ifdef NEXT_HOP_RETRY_EN
                        r_retry     <= '0;
`endif
                        r_state     <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end else if (chk_is_broadcast || chk_is_subnet_broadcast) begin
                        m_res_mac   <= BCAST_MAC;
                        m_res_bcast <= 1'b1;
                        m_res_error <= 1'b0;
                        m_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        arp_req_ip    <= chk_is_local ? chk_dest_ip : r_gateway;
                        arp_req_valid <= 1'b1;
                        r_state       <= ST_LOOKUP;
                    end
                end

                ST_LOOKUP: begin
                    if (arp_req_ready) begin
                        arp_req_valid <= 1'b0;
                        r_cnt         <= c_timeout_load;
                        r_state       <= ST_WAIT_RESP;
                    end
                end

                ST_WAIT_RESP: begin
                    // A response in the expiry cycle takes priority over the timeout.
                    if (arp_resp_valid) begin
                        m_res_mac   <= arp_resp_error ? '0 : arp_resp_mac;
                        m_res_error <= arp_resp_error;
                        m_res_bcast <= 1'b0;
                        m_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (r_cnt <= c_cnt_one) begin
`ifdef NEXT_HOP_RETRY_EN
                        if (r_retry < c_max_retries) begin
                            r_retry       <= r_retry + c_retry_one;
                            arp_req_valid <= 1'b1;
                            r_state       <= ST_LOOKUP;
                        end else begin
                            m_res_mac   <= '0;
                            m_res_error <= 1'b1;
                            m_res_bcast <= 1'b0;
                            m_res_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
`else
                        m_res_mac   <= '0;
                        m_res_error <= 1'b1;
                        m_res_bcast <= 1'b0;
                        m_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
`endif
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end

                ST_DONE: begin
                    if (m_res_ready) begin
                        m_res_valid <= 1'b0;
                        busy        <= 1'b0;
                        s_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_next_hop_resolver.sv
`default_nettype none
// ============================================================================
// Module      : tb_next_hop_resolver
// Description : Scoreboard bench for next_hop_resolver with a checker model
//               (subnet C0A80100/24, two-cycle flag latency) and ARP driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_next_hop_resolver;

    localparam int          CHK_LAT = 2;
    localparam int          TMO     = 16;
    localparam int          RETRIES = 3;
    localparam logic [31:0] GW      = 32'hC0A8_0101;
    localparam logic [31:0] MASK    = 32'hFFFF_FF00;
`ifdef NEXT_HOP_RETRY_EN
    localparam int          EXP_ATTEMPTS = RETRIES + 1;
`else
    localparam int          EXP_ATTEMPTS = 1;
`endif

    typedef struct packed {
        logic [47:0] mac;
        logic        bcast;
        logic        err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_req_valid = 1'b0;
    logic        s_req_ready;
    logic [31:0] s_req_ip = '0;
    logic [31:0] gateway_ip = GW;
    logic [31:0] chk_dest_ip;
    logic        arp_req_valid;
    logic        arp_req_ready = 1'b0;
    logic [31:0] arp_req_ip;
    logic        arp_resp_valid = 1'b0;
    logic        arp_resp_ready;
    logic        arp_resp_error = 1'b0;
    logic [47:0] arp_resp_mac = '0;
    logic        m_res_valid;
    logic        m_res_ready = 1'b0;
    logic [47:0] m_res_mac;
    logic        m_res_bcast;
    logic        m_res_error;
    logic        busy;

    logic [2:0]  w_flags;
    logic [2:0]  r_p1 = '0;
    logic [2:0]  r_p2 = '0;

    res_t        exp_q[$];
    res_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc = 0;
    int          hs_cnt = 0;
    int          hs_cyc = 0;
    int          arp_valid_cycles = 0;
    int          h0;
    int          av0;

    next_hop_resolver #(
        .CHK_LATENCY    (CHK_LAT),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES    (RETRIES)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .s_req_valid             (s_req_valid),
        .s_req_ready             (s_req_ready),
        .s_req_ip                (s_req_ip),
        .gateway_ip              (gateway_ip),
        .chk_dest_ip             (chk_dest_ip),
        .chk_is_broadcast        (r_p2[2]),
        .chk_is_subnet_broadcast (r_p2[1]),
        .chk_is_local            (r_p2[0]),
        .arp_req_valid           (arp_req_valid),
        .arp_req_ready           (arp_req_ready),
        .arp_req_ip              (arp_req_ip),
        .arp_resp_valid          (arp_resp_valid),
        .arp_resp_ready          (arp_resp_ready),
        .arp_resp_error          (arp_resp_error),
        .arp_resp_mac            (arp_resp_mac),
        .m_res_valid             (m_res_valid),
        .m_res_ready             (m_res_ready),
        .m_res_mac               (m_res_mac),
        .m_res_bcast             (m_res_bcast),
        .m_res_error             (m_res_error),
        .busy                    (busy)
    );

    always #5 clk = ~clk;

    // Checker model: flags settle two clocks after chk_dest_ip changes.
    always_comb begin
        w_flags    = '0;
        w_flags[2] = (chk_dest_ip == 32'hFFFF_FFFF);
        w_flags[1] = ((chk_dest_ip & MASK) == (GW & MASK)) && ((chk_dest_ip & ~MASK) == ~MASK);
        w_flags[0] = ((chk_dest_ip & MASK) == (GW & MASK));
    end

    always @(posedge clk) begin
        r_p1 <= w_flags;
        r_p2 <= r_p1;
        cyc  <= cyc + 1;
        if (arp_req_valid)
            arp_valid_cycles <= arp_valid_cycles + 1;
        if (arp_req_valid && arp_req_ready) begin
            hs_cnt <= hs_cnt + 1;
            hs_cyc <= cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every consumed result is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && m_res_valid && m_res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got mac=%h bcast=%b err=%b expected none",
                         m_res_mac, m_res_bcast, m_res_error);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", {14'd0, m_res_mac, m_res_bcast, m_res_error}, {14'd0, mon_e});
            end
        end
    end

    task automatic send(input logic [31:0] ip);
        int n = 0;
        s_req_ip    = ip;
        s_req_valid = 1'b1;
        while (!s_req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready", {63'd0, s_req_ready}, 64'd1);
        @(posedge clk); #1;
        s_req_valid = 1'b0;
        acc = cyc - 1;
    endtask

    task automatic wait_res(input string name, input int exp_cyc, input int max_wait);
        int n = 0;
        while (!m_res_valid && n < max_wait) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_valid"}, {63'd0, m_res_valid}, 64'd1);
        if (exp_cyc >= 0)
            chk({name, "_cycle"}, 64'(cyc - acc), 64'(exp_cyc));
    endtask

    task automatic wait_arp(input string name, input int exp_cyc);
        int n = 0;
        while (!arp_req_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_arp_valid"}, {63'd0, arp_req_valid}, 64'd1);
        chk({name, "_arp_cycle"}, 64'(cyc - acc), 64'(exp_cyc));
    endtask

    task automatic arp_handshake();
        arp_req_ready = 1'b1;
        @(posedge clk); #1;
        arp_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [47:0] mac, input logic err);
        arp_resp_valid = 1'b1;
        arp_resp_mac   = mac;
        arp_resp_error = err;
        @(posedge clk); #1;
        arp_resp_valid = 1'b0;
        chk("valid_after_resp", {63'd0, m_res_valid}, 64'd1);
    endtask

    task automatic consume();
        m_res_ready = 1'b1;
        @(posedge clk); #1;
        m_res_ready = 1'b0;
        chk("busy_after_done", {63'd0, busy}, 64'd0);
        chk("ready_after_done", {63'd0, s_req_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {m_res_valid, arp_req_valid, busy, m_res_bcast, m_res_error, chk_dest_ip},
            64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_ready", {62'd0, s_req_ready, arp_resp_ready}, 64'd3);

        // Limited broadcast
        av0 = arp_valid_cycles;
        exp_q.push_back({48'hFFFF_FFFF_FFFF, 1'b1, 1'b0});
        send(32'hFFFF_FFFF);
        wait_res("bcast", CHK_LAT + 2, 20);
        consume();
        chk("bcast_no_arp", 64'(arp_valid_cycles), 64'(av0));

        // Subnet broadcast with a stalled consumer
        exp_q.push_back({48'hFFFF_FFFF_FFFF, 1'b1, 1'b0});
        send(32'hC0A8_01FF);
        wait_res("sbcast", CHK_LAT + 2, 20);
        repeat (5) begin
            chk("stall_hold", {12'd0, m_res_valid, s_req_ready, m_res_bcast, m_res_error, m_res_mac},
                {12'd0, 1'b1, 1'b0, 1'b1, 1'b0, 48'hFFFF_FFFF_FFFF});
            @(posedge clk); #1;
        end
        consume();

        // Local destination with ARP backpressure
        exp_q.push_back({48'h0011_2233_4455, 1'b0, 1'b0});
        send(32'hC0A8_0164);
        wait_arp("local", CHK_LAT + 2);
        chk("local_arp_ip", {32'd0, arp_req_ip}, {32'd0, 32'hC0A8_0164});
        repeat (3) begin
            @(posedge clk); #1;
            chk("arp_hold", {31'd0, arp_req_valid, arp_req_ip}, {31'd0, 1'b1, 32'hC0A8_0164});
        end
        arp_handshake();
        chk("arp_drop", {63'd0, arp_req_valid}, 64'd0);
        respond(48'h0011_2233_4455, 1'b0);
        consume();

        // Remote destination, cache miss
        exp_q.push_back({48'h0, 1'b0, 1'b1});
        send(32'h0808_0808);
        wait_arp("remote", CHK_LAT + 2);
        chk("remote_arp_ip", {32'd0, arp_req_ip}, {32'd0, GW});
        arp_handshake();
        respond(48'hDEAD_BEEF_0001, 1'b1);
        consume();

        // No response at all: expiry cycle is TMO cycles after the handshake
        exp_q.push_back({48'h0, 1'b0, 1'b1});
        h0 = hs_cnt;
        arp_req_ready = 1'b1;
        send(32'h0A00_0001);
        wait_res("timeout", -1, 300);
        arp_req_ready = 1'b0;
        chk("timeout_attempts", 64'(hs_cnt - h0), 64'(EXP_ATTEMPTS));
        chk("timeout_latency", 64'(cyc - hs_cyc), 64'(TMO + 1));
        consume();

        // Response landing on the expiry cycle wins
        exp_q.push_back({48'hAABB_CCDD_EEFF, 1'b0, 1'b0});
        send(32'hC0A8_0120);
        wait_arp("expiry", CHK_LAT + 2);
        h0 = hs_cnt;
        arp_handshake();
        repeat (TMO - 1) begin
            @(posedge clk); #1;
        end
        respond(48'hAABB_CCDD_EEFF, 1'b0);
        chk("expiry_no_retry", 64'(hs_cnt - h0), 64'd1);
        consume();

        // Asynchronous reset while waiting for a response
        send(32'hC0A8_0164);
        wait_arp("pre_rst", CHK_LAT + 2);
        arp_handshake();
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("async_rst_a", {arp_req_ip, chk_dest_ip}, 64'd0);
        chk("async_rst_b", {9'd0, m_res_mac, m_res_valid, m_res_bcast, m_res_error,
                            arp_req_valid, busy, s_req_ready, arp_resp_ready}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {62'd0, busy, s_req_ready}, 64'd1);

        exp_q.push_back({48'h0A0B_0C0D_0E0F, 1'b0, 1'b0});
        send(32'hC0A8_0105);
        wait_arp("post_rst", CHK_LAT + 2);
        chk("post_rst_arp_ip", {32'd0, arp_req_ip}, {32'd0, 32'hC0A8_0105});
        arp_handshake();
        respond(48'h0A0B_0C0D_0E0F, 1'b0);
        consume();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
